pci_burst_counter: RTL and testbench
====================================

PCI_BURST_COUNTER -- requirements
Module: pci_burst_counter

Interface
REQ-001 Parameter CNT_W, default 4: width of the burst-length field and the remaining-phase counter.
REQ-002 Parameter TMO_CYC, default 16: consecutive cycles without TRDY# before timeout (used only with PCI_WAIT_TMO_EN).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load  in  1  address-phase strobe; high for one cycle to start a burst.
REQ-006 len  in  CNT_W  number of data phases in the burst, sampled with load.
REQ-007 irdy_n  in  1  PCI IRDY#, active-low.
REQ-008 trdy_n  in  1  PCI TRDY#, active-low.
REQ-009 stop_n  in  1  PCI STOP#, active-low.
REQ-010 busy  out  1  high while in XFER.
REQ-011 remaining  out  CNT_W  data phases still to complete.
REQ-012 last  out  1  high in XFER when remaining==1 (combinational from registered state).
REQ-013 done  out  1  one-cycle pulse: the burst completed all phases.
REQ-014 disc  out  1  one-cycle pulse: target STOP# ended the burst early.
REQ-015 len_err  out  1  one-cycle pulse: load seen with len==0.
REQ-016 tmo  out  1  one-cycle pulse: wait timeout (tied 0 without PCI_WAIT_TMO_EN).

Function
REQ-017 The FSM SHALL have two states, IDLE and XFER; done, disc, len_err and tmo SHALL be registered pulses.
REQ-018 In IDLE, load=1 with len!=0 SHALL set remaining=len and enter XFER on the next edge.
REQ-019 In IDLE, load=1 with len==0 SHALL pulse len_err in the next cycle, stay in IDLE and leave remaining unchanged.
REQ-020 A data phase SHALL complete in any XFER cycle with irdy_n==0 and trdy_n==0; remaining SHALL then decrement by 1.
REQ-021 A completed phase with remaining==1 SHALL set remaining=0, return to IDLE and pulse done in the next cycle.
REQ-022 stop_n==0 in XFER SHALL return to IDLE at the next edge; if that cycle also completes the final phase, done SHALL pulse and disc SHALL NOT; otherwise disc SHALL pulse.
REQ-023 On disconnect, remaining SHALL hold the untransferred count (after any decrement in the same cycle) until the next accepted load.
REQ-024 load asserted during XFER SHALL be ignored with no error pulse.
REQ-025 load in the same cycle that XFER exits SHALL be ignored; a new burst requires load while in IDLE.
REQ-026 remaining SHALL never wrap below 0; no decrement occurs outside XFER.
REQ-027 At most one of done, disc and tmo SHALL assert in any cycle.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, remaining=0, all pulses=0 and the wait counter=0, regardless of clk.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no done or disc pulse.
REQ-030 The first load honoured SHALL be on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro PCI_WAIT_TMO_EN defined: an internal counter SHALL count consecutive XFER cycles with trdy_n==1, clear on trdy_n==0 or on XFER entry, and on reaching TMO_CYC SHALL pulse tmo and return to IDLE with remaining held.
REQ-032 In the TMO_CYC-th cycle, stop_n==0 SHALL take priority over tmo, so disc pulses and tmo does not.
REQ-033 Macro not defined: no wait counter logic SHALL exist, tmo SHALL be constant 0, and XFER SHALL wait indefinitely.

Verification
REQ-034 CNT_W=4: load with len=3, irdy_n=trdy_n=0 for 3 cycles -> remaining 3,2,1,0; last high in the third cycle; done pulses once; busy low afterwards.
REQ-035 len=4, trdy_n toggling 1/0 with irdy_n=0 -> 4 completed phases over 8 cycles, then done; remaining unchanged in wait cycles.
REQ-036 len=5, 2 phases complete, then stop_n=0 with trdy_n=1 -> disc pulse, remaining=3, IDLE; load during the burst produces no effect.
REQ-037 load with len=0 -> len_err pulse, busy stays 0. len=1 with stop_n=0 on its only completed phase -> done pulse, no disc.
REQ-038 rst pulse mid-burst with remaining=2 -> remaining=0, busy=0 immediately; no done or disc pulse.
REQ-039 PCI_WAIT_TMO_EN, TMO_CYC=16, trdy_n held 1 -> tmo pulse after 16 XFER cycles. Without the macro -> tmo=0 and busy is still high at 100 cycles.

Source files
------------

// File: rtl/pci_burst_counter.sv
// PCI burst data-phase counter: tracks remaining phases and flags done/disconnect/len errors.
// Optional TRDY# wait timeout is built only when PCI_WAIT_TMO_EN is defined.
module pci_burst_counter #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TMO_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             irdy_n,
    input  logic             trdy_n,
    input  logic             stop_n,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             last,
    output logic             done,
    output logic             disc,
    output logic             len_err,
    output logic             tmo
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             disc_q, disc_d;
    logic             len_err_q, len_err_d;
    logic             phase_ok;

    assign phase_ok = (state_q == XFER) && !irdy_n && !trdy_n;

`ifdef PCI_WAIT_TMO_EN
    // Counter only needs to reach TMO_CYC-1; the TMO_CYC-th waiting cycle fires the timeout.
    localparam int unsigned WCNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              tmo_q, tmo_d;
    logic              wait_expired;

    assign wait_expired = (state_q == XFER) && trdy_n && (wcnt_q == WCNT_W'(TMO_CYC - 1));
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        disc_d    = 1'b0;
        len_err_d = 1'b0;
`ifdef PCI_WAIT_TMO_EN
        tmo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = XFER;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            XFER: begin
                if (phase_ok && rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end
                // Final-phase completion outranks STOP#, which outranks the wait timeout.
                if (phase_ok && rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (!stop_n) begin
                    state_d = IDLE;
                    disc_d  = 1'b1;
                end
`ifdef PCI_WAIT_TMO_EN
                else if (wait_expired) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PCI_WAIT_TMO_EN
    always_comb begin
        wcnt_d = '0;
        if (state_q == XFER && state_d == XFER && trdy_n) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            done_q    <= 1'b0;
            disc_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            disc_q    <= disc_d;
            len_err_q <= len_err_d;
        end
    end

    assign busy      = (state_q == XFER);
    assign remaining = rem_q;
    assign last      = (state_q == XFER) && (rem_q == CNT_W'(1));
    assign done      = done_q;
    assign disc      = disc_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_pci_burst_counter.sv
// Directed self-checking bench for pci_burst_counter (CNT_W=4, TMO_CYC=16).
// Timeout checks follow PCI_WAIT_TMO_EN so the bench matches either build.
module tb_pci_burst_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] len;
    logic       irdy_n;
    logic       trdy_n;
    logic       stop_n;
    logic       busy;
    logic [3:0] remaining;
    logic       last;
    logic       done;
    logic       disc;
    logic       len_err;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    pci_burst_counter #(.CNT_W(4), .TMO_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .len       (len),
        .irdy_n    (irdy_n),
        .trdy_n    (trdy_n),
        .stop_n    (stop_n),
        .busy      (busy),
        .remaining (remaining),
        .last      (last),
        .done      (done),
        .disc      (disc),
        .len_err   (len_err),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load   = 1'b0;
        len    = 4'd0;
        irdy_n = 1'b1;
        trdy_n = 1'b1;
        stop_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rem;

        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_pulses", {done, disc, len_err, tmo}, 0);
        step();
        rst = 1'b0;

        // 3-phase burst, no waits
        load = 1'b1; len = 4'd3;
        step();
        chk("b3_busy", busy, 1);
        chk("b3_rem3", remaining, 3);
        chk("b3_last0", last, 0);
        load = 1'b0; irdy_n = 1'b0; trdy_n = 1'b0;
        step();
        chk("b3_rem2", remaining, 2);
        chk("b3_done0", done, 0);
        step();
        chk("b3_rem1", remaining, 1);
        chk("b3_last1", last, 1);
        step();
        chk("b3_rem0", remaining, 0);
        chk("b3_done1", done, 1);
        chk("b3_busy0", busy, 0);
        chk("b3_last_idle", last, 0);
        idle_inputs();
        step();
        chk("b3_done_once", done, 0);
        chk("b3_busy_after", busy, 0);

        // 4-phase burst with TRDY# alternating wait/complete
        load = 1'b1; len = 4'd4;
        step();
        chk("b4_rem4", remaining, 4);
        load = 1'b0; irdy_n = 1'b0;
        exp_rem = 4'd4;
        for (int i = 0; i < 8; i++) begin
            trdy_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (!trdy_n) exp_rem = exp_rem - 4'd1;
            step();
            chk("b4_rem", remaining, exp_rem);
            chk("b4_done", done, (i == 7) ? 1 : 0);
            chk("b4_busy", busy, (i == 7) ? 0 : 1);
        end
        idle_inputs();
        step();

        // 5-phase burst, 2 phases then STOP# without TRDY#; load mid-burst ignored
        load = 1'b1; len = 4'd5;
        step();
        chk("b5_rem5", remaining, 5);
        load = 1'b1; len = 4'd9; irdy_n = 1'b0; trdy_n = 1'b0;
        step();
        chk("b5_rem4_ignore_load", remaining, 4);
        len = 4'd0;
        step();
        chk("b5_rem3", remaining, 3);
        chk("b5_no_lenerr", len_err, 0);
        load = 1'b0; trdy_n = 1'b1; stop_n = 1'b0;
        step();
        chk("b5_disc1", disc, 1);
        chk("b5_done0", done, 0);
        chk("b5_busy0", busy, 0);
        chk("b5_rem_held", remaining, 3);
        idle_inputs();
        step();
        chk("b5_disc_pulse", disc, 0);
        chk("b5_rem_still", remaining, 3);

        // Zero-length load
        load = 1'b1; len = 4'd0;
        step();
        chk("z_lenerr1", len_err, 1);
        chk("z_busy0", busy, 0);
        chk("z_rem_unch", remaining, 3);
        load = 1'b0;
        step();
        chk("z_lenerr0", len_err, 0);

        // 1-phase burst whose only phase coincides with STOP#; load in exit cycle ignored
        load = 1'b1; len = 4'd1;
        step();
        chk("b1_rem1", remaining, 1);
        chk("b1_last", last, 1);
        load = 1'b1; len = 4'd2; irdy_n = 1'b0; trdy_n = 1'b0; stop_n = 1'b0;
        step();
        chk("b1_done1", done, 1);
        chk("b1_disc0", disc, 0);
        chk("b1_busy0", busy, 0);
        chk("b1_rem0", remaining, 0);
        idle_inputs();
        step();
        chk("exit_load_ignored", busy, 0);

        // Reset in the middle of a burst
        load = 1'b1; len = 4'd4;
        step();
        load = 1'b0; irdy_n = 1'b0; trdy_n = 1'b0;
        step();
        step();
        chk("r_rem2", remaining, 2);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("r_async_rem", remaining, 0);
        chk("r_async_busy", busy, 0);
        step();
        chk("r_no_pulse", {done, disc}, 0);
        rst = 1'b0;
        load = 1'b1; len = 4'd2;
        step();
        chk("r_first_load", busy, 1);
        chk("r_first_rem", remaining, 2);

        // Endless TRDY# wait
        load = 1'b0; irdy_n = 1'b0; trdy_n = 1'b1;
`ifdef PCI_WAIT_TMO_EN
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t_tmo", tmo, (i == 16) ? 1 : 0);
            chk("t_busy", busy, (i == 16) ? 0 : 1);
        end
        chk("t_rem_held", remaining, 2);
        chk("t_no_done_disc", {done, disc}, 0);
        idle_inputs();
        step();
        chk("t_tmo_pulse", tmo, 0);
`else
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("t_tmo0", tmo, 0);
        end
        chk("t_busy_100", busy, 1);
        chk("t_rem_100", remaining, 2);
        trdy_n = 1'b0;
        step();
        step();
        chk("t_late_done", done, 1);
        idle_inputs();
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
